// File: rtl/layer_scheduler.sv
// Steps one shared neuron datapath through every neuron of a fully-connected layer.
// Define LAYER_TIMEOUT_EN to abort the layer when a neuron fails to answer within TIMEOUT WAIT cycles.
module layer_scheduler #(
    parameter int NUM_NEURONS = 10,
    parameter int IDX_W       = 6,
    parameter int TIMEOUT     = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             neuron_ready,
    output logic             neuron_start,
    output logic [IDX_W-1:0] neuron_sel,
    output logic             out_wr_en,
    output logic [IDX_W-1:0] out_addr,
    output logic             busy,
    output logic             layer_done,
    output logic             timeout_err
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ISSUE = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_WRITE = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NEURONS - 1);

    if (NUM_NEURONS < 1 || TIMEOUT < 1 || NUM_NEURONS > (1 << IDX_W)) begin : g_bad_cfg
        $error("layer_scheduler: illegal NUM_NEURONS/IDX_W/TIMEOUT combination");
    end

    logic [2:0]       state;
    logic [IDX_W-1:0] idx;
    logic             wait_expired;

`ifdef LAYER_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] wait_cnt;
    logic             err_q;

    assign wait_expired = (state == S_WAIT) && (wait_cnt == CNT_W'(TIMEOUT - 1));

    // Counter is held at zero outside WAIT, so it restarts on every WAIT entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt <= '0;
            err_q    <= 1'b0;
        end else begin
            if (state == S_WAIT)
                wait_cnt <= wait_cnt + CNT_W'(1);
            else
                wait_cnt <= '0;

            if (state == S_IDLE && start)
                err_q <= 1'b0;
            else if (wait_expired && !neuron_ready)
                err_q <= 1'b1;
        end
    end

    assign timeout_err = err_q;
`else
    assign wait_expired = 1'b0;
    assign timeout_err  = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            idx   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        idx   <= '0;
                        state <= S_ISSUE;
                    end
                end
                S_ISSUE: state <= S_WAIT;
                S_WAIT: begin
                    // A real ready wins over a timeout landing in the same cycle.
                    if (neuron_ready)
                        state <= S_WRITE;
                    else if (wait_expired)
                        state <= S_DONE;
                end
                S_WRITE: begin
                    if (idx == LAST_IDX) begin
                        state <= S_DONE;
                    end else begin
                        idx   <= idx + IDX_W'(1);
                        state <= S_ISSUE;
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign neuron_start = (state == S_ISSUE);
    assign neuron_sel   = idx;
    assign out_wr_en    = (state == S_WRITE);
    assign out_addr     = idx;
    assign busy         = (state != S_IDLE);
    assign layer_done   = (state == S_DONE);

endmodule

// File: tb/tb_layer_scheduler.sv
// Scoreboard bench for layer_scheduler: a 3-neuron instance (K=12 neuron model) and a 1-neuron instance (K=1).
module tb_layer_scheduler;

    localparam int IDX_W = 6;
    localparam int K     = 12;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // 3-neuron instance
    logic             start = 1'b0;
    logic             model_ready = 1'b0;
    logic             spur_ready = 1'b0;
    logic             neuron_ready;
    logic             n_start, wr_en, busy, done, terr;
    logic [IDX_W-1:0] n_sel, addr;
    bit               model_en = 1'b1;

    assign neuron_ready = model_ready | spur_ready;

    layer_scheduler #(.NUM_NEURONS(3), .IDX_W(IDX_W), .TIMEOUT(8)) u3 (
        .clk(clk), .rst(rst), .start(start), .neuron_ready(neuron_ready),
        .neuron_start(n_start), .neuron_sel(n_sel), .out_wr_en(wr_en),
        .out_addr(addr), .busy(busy), .layer_done(done), .timeout_err(terr)
    );

    // 1-neuron instance
    logic             start1 = 1'b0;
    logic             ready1 = 1'b0;
    logic             n_start1, wr_en1, busy1, done1, terr1;
    logic [IDX_W-1:0] n_sel1, addr1;

    layer_scheduler #(.NUM_NEURONS(1), .IDX_W(IDX_W), .TIMEOUT(8)) u1 (
        .clk(clk), .rst(rst), .start(start1), .neuron_ready(ready1),
        .neuron_start(n_start1), .neuron_sel(n_sel1), .out_wr_en(wr_en1),
        .out_addr(addr1), .busy(busy1), .layer_done(done1), .timeout_err(terr1)
    );

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    int exp_iss[$];
    int exp_wr[$];
    int exp_done[$];
    int exp1[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Neuron models: ready pulses K cycles after the ISSUE cycle.
    always begin
        @(negedge clk);
        if (n_start && model_en && !rst) begin
            repeat (K) @(posedge clk);
            #1 model_ready = 1'b1;
            @(posedge clk);
            #1 model_ready = 1'b0;
        end
    end

    always begin
        @(negedge clk);
        if (n_start1 && !rst) begin
            @(posedge clk);
            #1 ready1 = 1'b1;
            @(posedge clk);
            #1 ready1 = 1'b0;
        end
    end

    // Monitor for the 3-neuron instance
    int start_edge = 0;
    bit in_layer   = 1'b0;
    int busy_drops = 0;

    always @(negedge clk) begin
        if (rst) begin
            in_layer = 1'b0;
        end else begin
            if (n_start) begin
                if (exp_iss.size() == 0) check("extra_issue", int'(n_start), 0);
                else                     check("issue_sel", int'(n_sel), exp_iss.pop_front());
            end
            if (wr_en) begin
                if (exp_wr.size() == 0) check("extra_write", int'(wr_en), 0);
                else                    check("write_addr", int'(addr), exp_wr.pop_front());
            end
            if (in_layer && !busy) busy_drops++;
            if (done) begin
                if (exp_done.size() == 0) begin
                    check("extra_done", int'(done), 0);
                end else begin
                    check("done_latency", cyc - start_edge, exp_done.pop_front());
                    check("busy_held", busy_drops, 0);
                end
                in_layer = 1'b0;
            end
            if (start && !busy) begin
                start_edge = cyc + 1;
                in_layer   = 1'b1;
                busy_drops = 0;
            end
        end
    end

    // Monitor for the 1-neuron instance: one packed output vector per cycle
    always @(negedge clk) begin
        if (exp1.size() > 0)
            check("u1_cycle", int'({n_start1, busy1, wr_en1, done1, addr1}), exp1.pop_front());
    end

    task automatic pulse_start();
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic push_layer(input int latency);
        for (int i = 0; i < 3; i++) begin
            exp_iss.push_back(i);
            exp_wr.push_back(i);
        end
        exp_done.push_back(latency);
    endtask

    task automatic wait_done(input int bound);
        bit seen = 1'b0;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        check("done_seen", int'(seen), 1);
    endtask

    task automatic wait_issue1(input int bound);
        bit seen = 1'b0;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (n_start && n_sel == IDX_W'(1)) begin
                seen = 1'b1;
                break;
            end
        end
        check("issue1_seen", int'(seen), 1);
    endtask

    function automatic int vec(input bit s, input bit b, input bit w, input bit d, input int a);
        return (int'(s) << 9) | (int'(b) << 8) | (int'(w) << 7) | (int'(d) << 6) | a;
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", int'(busy), 0);
        check("rst_start", int'(n_start), 0);
        check("rst_sel", int'(n_sel), 0);
        check("rst_wr", int'(wr_en), 0);
        check("rst_done", int'(done), 0);
        check("rst_terr", int'(terr), 0);
        check("rst_u1_busy", int'(busy1), 0);
        rst = 1'b0;

        // Normal layer
        push_layer(3 * (K + 2));
        pulse_start();
        wait_done(200);
        @(negedge clk);
        check("idle_busy", int'(busy), 0);
        check("idx_hold", int'(n_sel), 2);

        // Start while busy is ignored
        push_layer(3 * (K + 2));
        pulse_start();
        wait_issue1(100);
        pulse_start();
        wait_done(200);
        repeat (3) @(negedge clk);
        check("busy_start_writes_left", exp_wr.size(), 0);

        // Spurious ready in IDLE, with start, and in ISSUE
        @(posedge clk);
        #1 spur_ready = 1'b1;
        @(posedge clk);
        #1 spur_ready = 1'b0;
        @(negedge clk);
        check("spur_idle_busy", int'(busy), 0);
        push_layer(3 * (K + 2));
        @(posedge clk);
        #1 begin start = 1'b1; spur_ready = 1'b1; end
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        #1 spur_ready = 1'b0;
        wait_done(200);

        // Reset during neuron 1's WAIT
        exp_iss.push_back(0);
        exp_iss.push_back(1);
        exp_wr.push_back(0);
        pulse_start();
        wait_issue1(100);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("mid_rst_busy", int'(busy), 0);
        check("mid_rst_sel", int'(n_sel), 0);
        check("mid_rst_start", int'(n_start), 0);
        check("mid_rst_wr", int'(wr_en), 0);
        check("mid_rst_addr", int'(addr), 0);
        check("mid_rst_done", int'(done), 0);
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (K + 5) @(negedge clk);
        check("post_rst_busy", int'(busy), 0);
        check("post_rst_writes_left", exp_wr.size(), 0);
        push_layer(3 * (K + 2));
        pulse_start();
        wait_done(200);

        // Single-neuron layer, K=1: ISSUE, WAIT, WRITE(0), DONE, IDLE
        @(posedge clk);
        #1 start1 = 1'b1;
        @(posedge clk);
        #1 start1 = 1'b0;
        exp1.push_back(vec(1, 1, 0, 0, 0));
        exp1.push_back(vec(0, 1, 0, 0, 0));
        exp1.push_back(vec(0, 1, 1, 0, 0));
        exp1.push_back(vec(0, 1, 0, 1, 0));
        exp1.push_back(vec(0, 0, 0, 0, 0));
        repeat (8) @(negedge clk);
        check("u1_seq_left", exp1.size(), 0);

`ifdef LAYER_TIMEOUT_EN
        // Neuron never answers: 8 WAIT cycles then DONE with the error flag
        model_en = 1'b0;
        exp_iss.push_back(0);
        exp_done.push_back(1 + 8);
        pulse_start();
        wait_done(50);
        check("timeout_err_set", int'(terr), 1);
        repeat (4) @(negedge clk);
        check("timeout_err_sticky", int'(terr), 1);
        check("timeout_idle", int'(busy), 0);
        model_en = 1'b1;
        push_layer(3 * (K + 2));
        pulse_start();
        @(negedge clk);
        check("timeout_err_cleared", int'(terr), 0);
        wait_done(200);
`else
        check("timeout_err_tied", int'(terr), 0);
`endif

        repeat (5) @(negedge clk);
        check("pending_issues", exp_iss.size(), 0);
        check("pending_writes", exp_wr.size(), 0);
        check("pending_dones", exp_done.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
